barrel_shifter_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter with five shift/rotate modes.
//  - One mux stage per shift-amount bit; every stage is registered.
//  - Valid/ready handshake on both sides with backpressure.
//  - Carry-out and zero flags.
//  - Sits between the operand source and the ALU result mux; replaces the fixed 4-bit shifter.

---
 rtl/barrel_shifter_pipe.sv | 144 ++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered mux stage per shift-amount bit,
// valid/ready on both sides, carry-out and zero flags aligned with the result.
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DIN,
  input  logic [SHW-1:0]   SEL,
  input  logic [2:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic             CARRY,
  output logic             ZERO
);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // One stage: returns {carry, data}. The carry of a shifting stage is the last
  // bit it pushes out, which is also the overall last bit out after earlier stages.
  function automatic logic [WIDTH:0] shift_stage(input logic [WIDTH-1:0] d,
                                                 input logic [2:0]       mode,
                                                 input logic             en,
                                                 input logic             c_in,
                                                 input int               amt);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] tmp;
    logic             c;
    r   = d;
    c   = c_in;
    tmp = {WIDTH{1'b0}};
    if (en) begin
      case (mode)
        MODE_SLL: begin
          r   = d << amt;
          tmp = d >> (WIDTH - amt);
          c   = tmp[0];
        end
        MODE_SRL: begin
          r   = d >> amt;
          tmp = d >> (amt - 1);
          c   = tmp[0];
        end
        MODE_SRA: begin
          r   = $unsigned($signed(d) >>> amt);
          tmp = d >> (amt - 1);
          c   = tmp[0];
        end
        MODE_ROL: begin
          r = (d << amt) | (d >> (WIDTH - amt));
          c = 1'b0;
        end
        MODE_ROR: begin
          r = (d >> amt) | (d << (WIDTH - amt));
          c = 1'b0;
        end
        default: begin
          r = d;
          c = 1'b0;
        end
      endcase
    end else begin
      r = d;
      c = c_in;
    end
    return {c, r};
  endfunction

  logic             valid_r [SHW];
  logic [WIDTH-1:0] data_r  [SHW];
  logic [2:0]       mode_r  [SHW];
  logic [SHW-1:0]   sel_r   [SHW];
  logic             carry_r [SHW];
  logic             zero_r;

  logic             src_valid [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [2:0]       src_mode  [SHW];
  logic [SHW-1:0]   src_sel   [SHW];
  logic             src_carry [SHW];
  logic [WIDTH:0]   nxt       [SHW];

  logic advance;

  assign advance  = !valid_r[SHW-1] || OUT_READY;
  assign IN_READY = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int AMT = 1 << k;
    if (k == 0) begin : g_head
      assign src_valid[k] = IN_VALID;
      assign src_data[k]  = DIN;
      assign src_mode[k]  = MODE;
      assign src_sel[k]   = SEL;
      assign src_carry[k] = 1'b0;
    end else begin : g_body
      assign src_valid[k] = valid_r[k-1];
      assign src_data[k]  = data_r[k-1];
      assign src_mode[k]  = mode_r[k-1];
      assign src_sel[k]   = sel_r[k-1];
      assign src_carry[k] = carry_r[k-1];
    end
    assign nxt[k] = shift_stage(src_data[k], src_mode[k], src_sel[k][k], src_carry[k], AMT);
  end

  // Whole pipe moves together; a stall freezes every stage and the flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= 1'b0;
        data_r[k]  <= {WIDTH{1'b0}};
        mode_r[k]  <= 3'b000;
        sel_r[k]   <= {SHW{1'b0}};
        carry_r[k] <= 1'b0;
      end
      zero_r <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        valid_r[k] <= src_valid[k];
        data_r[k]  <= nxt[k][WIDTH-1:0];
        mode_r[k]  <= src_mode[k];
        sel_r[k]   <= src_sel[k];
        carry_r[k] <= nxt[k][WIDTH];
      end
      zero_r <= (nxt[SHW-1][WIDTH-1:0] == {WIDTH{1'b0}});
    end else begin
      zero_r <= zero_r;
    end
  end

  assign OUT_VALID = valid_r[SHW-1];
  assign DOUT      = data_r[SHW-1];
  assign CARRY     = carry_r[SHW-1];
  assign ZERO      = zero_r;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH=8): directed vectors push
// expected results; a negedge monitor pops and compares on every output transfer.
module tb_barrel_shifter_pipe;

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;

  logic       CLK = 1'b0;
  logic       RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY, CARRY, ZERO;
  logic [7:0] DIN, DOUT;
  logic [2:0] SEL, MODE;

  typedef struct {
    logic [7:0] d;
    logic       c;
    int         t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  barrel_shifter_pipe #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DIN(DIN), .SEL(SEL), .MODE(MODE), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .DOUT(DOUT), .CARRY(CARRY), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("dout", {24'd0, DOUT}, {24'd0, mon_e.d});
        check("carry", {31'd0, CARRY}, {31'd0, mon_e.c});
        check("zero", {31'd0, ZERO}, {31'd0, (mon_e.d == 8'h00)});
        if (mon_e.t >= 0) check("latency", cyc, mon_e.t);
      end
    end
  end

  // Present one operand until accepted; the expected result is queued at acceptance.
  task automatic send(input logic [7:0] din, input logic [2:0] sel, input logic [2:0] mode,
                      input logic [7:0] ed, input logic ec, input bit lat);
    bit   ok = 1'b0;
    exp_t e;
    IN_VALID = 1'b1; DIN = din; SEL = sel; MODE = mode;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        e.d = ed; e.c = ec; e.t = lat ? cyc + 3 : -1;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge CLK);
    #1;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  int seen_valid;

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; DIN = 8'h00; SEL = 3'd0; MODE = 3'd0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_dout", {24'd0, DOUT}, 32'd0);
    check("rst_carry", {31'd0, CARRY}, 32'd0);
    check("rst_zero", {31'd0, ZERO}, 32'd0);
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK); #1;

    // Shifts, rotates, pass-through and corners streamed back to back.
    send(8'h96, 3'd3, SLL,    8'hB0, 1'b0, 1'b1);
    send(8'h96, 3'd2, SRA,    8'hE5, 1'b1, 1'b1);
    send(8'h96, 3'd2, SRL,    8'h25, 1'b1, 1'b1);
    send(8'h96, 3'd1, ROR,    8'h4B, 1'b0, 1'b1);
    send(8'h96, 3'd7, ROL,    8'h4B, 1'b0, 1'b1);
    send(8'h96, 3'd5, 3'b111, 8'h96, 1'b0, 1'b1);
    send(8'h01, 3'd7, SLL,    8'h80, 1'b0, 1'b1);
    send(8'h80, 3'd1, SLL,    8'h00, 1'b1, 1'b1);
    send(8'hA5, 3'd0, SRA,    8'hA5, 1'b0, 1'b1);
    send(8'h3C, 3'd0, SRL,    8'h3C, 1'b0, 1'b1);
    send(8'h80, 3'd7, SRA,    8'hFF, 1'b0, 1'b1);
    send(8'h80, 3'd7, SRL,    8'h01, 1'b0, 1'b1);
    send(8'h00, 3'd3, 3'b101, 8'h00, 1'b0, 1'b1);
    drain();

    // Backpressure: six operands against a stalled output.
    OUT_READY = 1'b0;
    fork
      begin
        send(8'h0F, 3'd1, SLL, 8'h1E, 1'b0, 1'b0);
        send(8'h0F, 3'd1, SRL, 8'h07, 1'b1, 1'b0);
        send(8'h81, 3'd1, ROL, 8'h03, 1'b0, 1'b0);
        send(8'h81, 3'd1, ROR, 8'hC0, 1'b0, 1'b0);
        send(8'h40, 3'd6, SRA, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 3'd4, SLL, 8'hF0, 1'b1, 1'b0);
      end
      begin
        repeat (8) @(negedge CLK);
        check("stall_in_ready", {31'd0, IN_READY}, 32'd0);
        check("stall_out_valid", {31'd0, OUT_VALID}, 32'd1);
        check("stall_dout", {24'd0, DOUT}, 32'h1E);
        check("stall_queue", sb.size(), 32'd3);
        repeat (3) @(negedge CLK);
        check("stall_dout_hold", {24'd0, DOUT}, 32'h1E);
        check("stall_carry_hold", {31'd0, CARRY}, 32'd0);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
      end
    join
    drain();

    // Reset with two operands in flight must discard them.
    send(8'h11, 3'd1, SLL, 8'h22, 1'b0, 1'b0);
    send(8'h22, 3'd1, SLL, 8'h44, 1'b0, 1'b0);
    RST = 1'b1;
    sb.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    seen_valid = 0;
    repeat (5) begin
      @(negedge CLK);
      if (OUT_VALID) seen_valid++;
    end
    check("flush_no_valid", seen_valid, 32'd0);
    @(posedge CLK); #1;
    send(8'h96, 3'd3, SRL, 8'h12, 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
